// File: rtl/mag_cmp_seq.sv
// mag_cmp_seq
// Sequential magnitude comparator. It compares two WIDTH-bit operands one
// DIGIT-bit slice per clock, starting at the MSB slice, and stops on the first
// unequal slice. When every slice is equal, the cascade input i is forwarded
// unchanged, in the same way as a 74HC85 stage.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands, cascade input and mode are present
//   in_ready   block can accept (high only in IDLE)
//   a, b       operands (the result is A relative to B)
//   i          cascade input {gt, eq, lt} from a lower-order stage
//   sgn        1 = two's-complement compare, 0 = unsigned
//   out_valid  result valid (high in DONE)
//   out_ready  consumer takes the result
//   y          result {gt, eq, lt}; held until the next result or reset
module mag_cmp_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       i,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       y
);

    localparam int NS = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int KW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [KW-1:0]    K_TOP    = KW'(NS - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if (DIGIT < 1 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("mag_cmp_seq: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       i_q;
    logic [KW-1:0]    k;

    logic [DIGIT-1:0] a_top;
    logic [DIGIT-1:0] b_top;
    logic             slice_gt;
    logic             slice_lt;

    // The operands are shifted left by one slice after each equal compare.
    // As a result, the slice under test is always the top DIGIT bits, and no
    // variable part-select is needed. The counter k tracks which original
    // slice is under test.
    always_comb begin
        a_top    = a_q[WIDTH-1 -: DIGIT];
        b_top    = b_q[WIDTH-1 -: DIGIT];
        slice_gt = (a_top > b_top);
        slice_lt = (a_top < b_top);
    end

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                if (slice_gt || slice_lt || (k == '0)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- outputs: pure state decode, no path from in_valid/out_ready ----
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // ---- operand capture and slice walk ----
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            i_q <= '0;
            k   <= K_TOP;
            y   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Flipping the sign bit of both operands maps the
                        // two's-complement order onto the unsigned order.
                        a_q <= sgn ? (a ^ MSB_MASK) : a;
                        b_q <= sgn ? (b ^ MSB_MASK) : b;
                        i_q <= i;
                        k   <= K_TOP;
                    end
                end
                CMP: begin
                    if (slice_gt) begin
                        y <= 3'b100;
                    end else if (slice_lt) begin
                        y <= 3'b001;
                    end else if (k == '0) begin
                        // The cascade input passes through unchanged, even
                        // when it is not one-hot.
                        y <= i_q;
                    end else begin
                        k   <= k - KW'(1);
                        a_q <= a_q << DIGIT;
                        b_q <= b_q << DIGIT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mag_cmp_seq.sv
// tb_mag_cmp_seq
// Drives an 8-bit instance and a 16-bit instance of mag_cmp_seq. Expected
// results are pushed to a scoreboard queue at drive time. They are popped
// and compared when out_valid rises.
module tb_mag_cmp_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  i;
    logic        sgn;
    logic        sel16;

    logic       in_valid8, out_ready8, in_ready8, out_valid8;
    logic       in_valid16, out_ready16, in_ready16, out_valid16;
    logic [2:0] y8, y16;

    logic       in_ready_cur, out_valid_cur;
    logic [2:0] y_cur;

    assign in_valid8   = in_valid & ~sel16;
    assign out_ready8  = out_ready & ~sel16;
    assign in_valid16  = in_valid & sel16;
    assign out_ready16 = out_ready & sel16;

    assign in_ready_cur  = sel16 ? in_ready16 : in_ready8;
    assign out_valid_cur = sel16 ? out_valid16 : out_valid8;
    assign y_cur         = sel16 ? y16 : y8;

    always #5 clk = ~clk;

    mag_cmp_seq #(.WIDTH(8), .DIGIT(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a[7:0]), .b(b[7:0]), .i(i), .sgn(sgn),
        .out_valid(out_valid8), .out_ready(out_ready8), .y(y8)
    );

    mag_cmp_seq #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a), .b(b), .i(i), .sgn(sgn),
        .out_valid(out_valid16), .out_ready(out_ready16), .y(y16)
    );

    typedef struct {
        logic [2:0] y;
        int         m;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Number of slices examined: 1-based position of the first differing
    // 4-bit slice from the MSB, or NS when all slices are equal.
    function automatic int model_m(input int w, input logic [15:0] av, input logic [15:0] bv);
        int ns = w / 4;
        for (int s = ns - 1; s >= 0; s--) begin
            if (((av >> (4 * s)) & 16'hF) != ((bv >> (4 * s)) & 16'hF)) return ns - s;
        end
        return ns;
    endfunction

    function automatic longint as_val(input int w, input logic [15:0] v, input logic s);
        longint r = (w == 16) ? longint'(v) : longint'(v[7:0]);
        if (s && r[w-1]) r = r - (longint'(1) << w);
        return r;
    endfunction

    task automatic run(input bit w16, input logic [15:0] av, input logic [15:0] bv,
                       input logic [2:0] iv, input logic sv, input logic [2:0] ey,
                       input int hold);
        exp_t e;
        int   m;
        sel16 = w16;
        e.y = ey;
        e.m = model_m(w16 ? 16 : 8, av, bv);
        sb.push_back(e);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready_cur), 32'd1);
        a = av; b = bv; i = iv; sgn = sv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        // The capture edge is done. Scramble the bus to show that the
        // in-flight transaction no longer depends on it.
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); i = 3'($urandom); sgn = ~sv;
        m = 0;
        forever begin
            @(posedge clk);
            m++;
            @(negedge clk);
            if (out_valid_cur) break;
            if (m >= 40) begin
                chk("timeout_out_valid", 32'(out_valid_cur), 32'd1);
                break;
            end
        end
        e = sb.pop_front();
        chk("y", 32'(y_cur), 32'(e.y));
        chk("latency_m", 32'(m), 32'(e.m));
        for (int h = 0; h < hold; h++) begin
            in_valid = (h % 2 == 0);
            a = 16'($urandom);
            @(negedge clk);
            chk("bp_y", 32'(y_cur), 32'(e.y));
            chk("bp_out_valid", 32'(out_valid_cur), 32'd1);
            chk("bp_in_ready", 32'(in_ready_cur), 32'd0);
        end
        // When there was backpressure, keep in_valid high on the hand-off
        // edge. It must not be accepted in that cycle.
        in_valid  = (hold > 0);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid_cur), 32'd0);
        chk("release_in_ready", 32'(in_ready_cur), 32'd1);
    endtask

    task automatic rand_txn(input bit w16, input logic s);
        int          w = w16 ? 16 : 8;
        logic [15:0] av, bv;
        logic [7:0]  la, lb;
        logic [2:0]  iv, ey;
        longint      ca, cb;
        av = 16'($urandom);
        case ($urandom % 3)
            0:       bv = 16'($urandom);
            1:       bv = av;
            default: bv = av ^ (16'h1 << ($urandom % w));
        endcase
        if (!w16) begin
            av[15:8] = 8'h00;
            bv[15:8] = 8'h00;
        end
        la = 8'($urandom);
        lb = ($urandom % 2 == 0) ? la : 8'($urandom);
        iv = {la > lb, la == lb, la < lb};
        ca = as_val(w, av, s) * 256 + longint'(la);
        cb = as_val(w, bv, s) * 256 + longint'(lb);
        ey = (ca > cb) ? 3'b100 : ((ca < cb) ? 3'b001 : 3'b010);
        run(w16, av, bv, iv, s, ey, int'($urandom % 3));
    endtask

    initial begin
        logic [2:0] casc [4];
        casc[0] = 3'b100; casc[1] = 3'b010; casc[2] = 3'b001; casc[3] = 3'b000;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; i = '0; sgn = 1'b0; sel16 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready8", 32'(in_ready8), 32'd1);
        chk("rst_out_valid8", 32'(out_valid8), 32'd0);
        chk("rst_y8", 32'(y8), 32'd0);
        chk("rst_in_ready16", 32'(in_ready16), 32'd1);
        chk("rst_out_valid16", 32'(out_valid16), 32'd0);
        chk("rst_y16", 32'(y16), 32'd0);

        // Directed 8-bit cases.
        run(1'b0, 16'h003A, 16'h003C, 3'b010, 1'b0, 3'b001, 3);
        run(1'b0, 16'h0080, 16'h007F, 3'b010, 1'b0, 3'b100, 0);
        run(1'b0, 16'h0080, 16'h007F, 3'b010, 1'b1, 3'b001, 0);
        for (int c = 0; c < 4; c++) begin
            run(1'b0, 16'h0055, 16'h0055, casc[c], 1'b0, casc[c], (c == 0) ? 3 : 0);
        end

        // 16-bit traffic before the abort test, so that y16 is non-zero.
        for (int n = 0; n < 16; n++) rand_txn(1'b1, 1'(n % 2));
        run(1'b1, 16'hF000, 16'h0FFF, 3'b010, 1'b0, 3'b100, 0);

        // Abort in the middle of the compare with a reset.
        sel16 = 1'b1;
        @(negedge clk);
        a = 16'h1234; b = 16'h1235; i = 3'b010; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid16), 32'd0);
        chk("abort_y", 32'(y16), 32'd0);
        chk("abort_in_ready", 32'(in_ready16), 32'd1);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("abort_no_late_valid", 32'(out_valid16), 32'd0);
        end
        run(1'b1, 16'h1234, 16'h1235, 3'b010, 1'b0, 3'b001, 0);

        // Randomised regression on both widths and both modes.
        for (int n = 0; n < 24; n++) rand_txn(1'b0, 1'(n % 2));
        for (int n = 0; n < 24; n++) rand_txn(1'b1, 1'(n % 2));

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mag_cmp_seq.md
# mag_cmp_seq

Parametrised, sequential successor to the 4-bit cascadable magnitude comparator. It compares two WIDTH-bit operands one DIGIT-bit slice per clock, MSB slice first, and stops early on the first unequal slice. When every slice is equal it forwards a cascade input, as the 74HC85 does. It sits between a valid/ready producer and consumer, and adds an optional two's-complement mode.

## Interface
- WIDTH, 8: operand width; must be a non-zero multiple of DIGIT. Elaboration error otherwise.
- DIGIT, 4: slice width compared per cycle. NS = WIDTH/DIGIT slices.
- clk  in  1  rising-edge clock, single domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and mode present
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- i  in  3  cascade input {gt, eq, lt} from a lower-order stage
- sgn  in  1  1 = two's-complement compare, 0 = unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- y  out  3  result {gt, eq, lt}

## Operation
- FSM states: IDLE, CMP, DONE.
- IDLE
  - in_ready=1.
  - On in_valid at a clock edge: capture a, b, i and sgn into registers, set slice index k=NS-1, go to CMP.
- Signed mode: invert bit WIDTH-1 of both captured operands at capture. The unsigned slice compare then yields the signed order.
- CMP: compare slice k of A and B (bits k*DIGIT+DIGIT-1 .. k*DIGIT), unsigned.
  - A slice > B slice: y=100, go to DONE.
  - A slice < B slice: y=001, go to DONE.
  - Equal and k>0: k=k-1, stay in CMP.
  - Equal and k=0: y = captured i verbatim, no one-hot cleanup, go to DONE.
- DONE
  - out_valid=1; y is held stable.
  - On out_ready: go to IDLE. out_valid drops after that edge.
- in_valid is ignored outside IDLE. No new transaction is accepted in the cycle a result is taken.
- Changes to a, b, i or sgn after capture have no effect on the transaction in flight.
- Result is "A relative to B". Equality and cascade pass-through match {a>b, a==b, a<b} when i is generated from the lower-order bits.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - y=000
  - k=NS-1
  - captured registers=0
- rst has priority over all other inputs. Asserted mid-CMP or in DONE, it aborts the transaction and drops out_valid at the next edge. Nothing is held over.
- Latency: edges are counted from the accept edge E0. out_valid is high after edge E0+m, where m is the number of slices examined (1 ≤ m ≤ NS).
  - First-slice decision: m=1.
  - Fully equal operands: m=NS.
- y changes only on the edge entering DONE. It keeps its last value in IDLE and CMP; it is not cleared until rst.
- Backpressure: DONE is held indefinitely while out_ready=0, with y and out_valid stable. in_ready=0 throughout.
- Throughput: one result per m+2 cycles at best (accept, m compare edges, hand-off).
- in_ready is a pure decode of state=IDLE and has no combinational path from in_valid or out_ready.

## Test plan
- WIDTH=8, unsigned: a=8'h3A, b=8'h3C, i=3'b010 -> y=001 (slice 1 equal, slice 0 A<C); out_valid 2 edges after accept.
- WIDTH=8: a=8'h80, b=8'h7F, sgn=0 -> y=100 after 1 edge. Same operands with sgn=1 -> y=001 after 1 edge.
- WIDTH=8: a=b=8'h55 with i=3'b100, then 010, then 001, then 000 -> y equals i verbatim each time; out_valid 2 edges after accept.
- Backpressure: after any result, hold out_ready=0 for 3 cycles while toggling in_valid and a -> y and out_valid stable, in_ready=0. Raise out_ready -> IDLE on the next edge, in_ready=1.
- Reset mid-operation: WIDTH=16, a=16'h1234, b=16'h1235. Assert rst on the second CMP cycle -> out_valid never rises, y=000, in_ready=1 after the reset edge. A re-run without reset gives y=001 after 4 edges.
- Randomised regression (WIDTH 8 and 16, both sgn values, i derived from the low bits of a wider operand pair) -> y matches {a>b, a==b, a<b} of the combined values. m equals the 1-based position of the first differing slice from the MSB, or NS if all slices are equal.
